// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the codec-side I2C target.
package i2c_codec_pkg;

    localparam logic [6:0] DEV_ADDR_WM8731 = 7'h1A;
    localparam int         I2C_FRAME_BYTES = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_REG,
        ST_ACK_R,
        ST_DAT,
        ST_ACK_D,
        ST_WAIT_STOP,
        ST_IGNORE
    } i2c_state_e;

    // States where an early STOP or START means an aborted addressed frame
    function automatic logic in_frame(input i2c_state_e s);
        return (s == ST_ACK_A) || (s == ST_REG) || (s == ST_ACK_R) ||
               (s == ST_DAT) || (s == ST_ACK_D);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-stage synchronizer for SCL/SDA plus edge, START and STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;
    logic       sda_rise, sda_fall;

    always_comb begin
        scl_d = {scl_q[1:0], scl_in};
        sda_d = {sda_q[1:0], sda_in};
    end

    // Idle bus is high, so resetting high avoids false edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign sda       = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign sda_rise  = sda_q[1] & ~sda_q[2];
    assign sda_fall  = ~sda_q[1] & sda_q[2];
    assign start_det = sda_fall & scl_q[1];
    assign stop_det  = sda_rise & scl_q[1];

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target: decodes addr/reg/data frames into 16-bit writes.
module i2c_codec_target
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_WM8731
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_sclk,
    input  logic        i2c_sdat_in,
    output logic        i2c_sdat_oe,
    output logic        wr_valid,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        frame_err
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (i2c_sclk),
        .sda_in    (i2c_sdat_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  dat_q, dat_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        wr_valid_q, wr_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [7:0]  byte_in;
    logic        last_bit;

    assign byte_in  = {shift_q[6:0], sda};
    assign last_bit = (cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        reg_d       = reg_q;
        dat_d       = dat_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_data_d   = wr_data_q;

        if (start_det) begin
            frame_err_d = in_frame(state_q);
            state_d     = ST_ADDR;
            cnt_d       = '0;
            shift_d     = '0;
            oe_d        = 1'b0;
            busy_d      = 1'b0;
        end else if (stop_det) begin
            if (state_q == ST_WAIT_STOP) begin
                wr_valid_d = 1'b1;
                wr_data_d  = {reg_q, dat_q};
            end else begin
                frame_err_d = in_frame(state_q);
            end
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (last_bit) begin
                            if (byte_in == {DEV_ADDR, 1'b0}) begin
                                state_d = ST_ACK_A;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_REG, ST_DAT, ST_WAIT_STOP: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (last_bit) begin
                            if (state_q == ST_REG) begin
                                reg_d   = byte_in;
                                state_d = ST_ACK_R;
                            end else if (state_q == ST_DAT) begin
                                dat_d   = byte_in;
                                state_d = ST_ACK_D;
                            end else begin
                                // Frames carry exactly three bytes
                                frame_err_d = 1'b1;
                                busy_d      = 1'b0;
                                state_d     = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ACK_A, ST_ACK_R, ST_ACK_D: begin
                    // First fall ends bit 8, second fall ends the ACK bit
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = '0;
                            if (state_q == ST_ACK_A)
                                state_d = ST_REG;
                            else if (state_q == ST_ACK_R)
                                state_d = ST_DAT;
                            else
                                state_d = ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            reg_q       <= '0;
            dat_q       <= '0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            reg_q       <= reg_d;
            dat_q       <= dat_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign i2c_sdat_oe = oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench: bit-banged I2C master on a wired-AND bus against a frame-level model.
module tb_i2c_codec_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        i2c_sdat_oe;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        busy;
    logic        frame_err;
    wire         sda_bus = m_sda & ~i2c_sdat_oe;

    i2c_codec_target dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2c_sclk    (m_scl),
        .i2c_sdat_in (sda_bus),
        .i2c_sdat_oe (i2c_sdat_oe),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          wv_cnt = 0;
    int          fe_cnt = 0;
    int          oe_cnt = 0;
    logic [15:0] model_wd = 16'h0000;

    always @(negedge clk) begin
        if (wr_valid) wv_cnt++;
        if (frame_err) fe_cnt++;
        if (i2c_sdat_oe) oe_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_clk(32);
        m_sda = 1'b0;
        wait_clk(32);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_scl = 1'b0;
        wait_clk(32);
        m_sda = 1'b0;
        wait_clk(32);
        m_scl = 1'b1;
        wait_clk(32);
        m_sda = 1'b1;
        wait_clk(64);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_scl = 1'b0;
            wait_clk(32);
            m_sda = b[i];
            wait_clk(32);
            m_scl = 1'b1;
            wait_clk(64);
        end
    endtask

    task automatic read_ack(output logic a, output logic bz);
        m_scl = 1'b0;
        wait_clk(32);
        m_sda = 1'b1;
        wait_clk(32);
        m_scl = 1'b1;
        wait_clk(32);
        @(negedge clk);
        a  = sda_bus;
        bz = busy;
        wait_clk(32);
    endtask

    // Frame-level reference: an addressed write of exactly three bytes
    // ended by STOP commits; any other length after a match is an abort.
    task automatic run_frame(input logic [7:0] fb [4], input int n);
        logic match, a, bz;
        int   wv0, fe0, oe0;
        match = (fb[0] == 8'h34);
        wv0 = wv_cnt;
        fe0 = fe_cnt;
        oe0 = oe_cnt;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            send_bits(fb[i]);
            read_ack(a, bz);
            check("ack", {31'd0, a}, {31'd0, !(match && i < 3)});
            if (match && i < 3) check("busy_in_frame", {31'd0, bz}, 1);
        end
        i2c_stop();
        wait_clk(16);
        if (match && n == 3) model_wd = {fb[1], fb[2]};
        check("wr_valid_pulses", wv_cnt - wv0, (match && n == 3) ? 1 : 0);
        check("frame_err_pulses", fe_cnt - fe0, (match && n != 3) ? 1 : 0);
        check("wr_data", {16'd0, wr_data}, {16'd0, model_wd});
        check("busy_after", {31'd0, busy}, 0);
        if (!match) check("oe_never", oe_cnt - oe0, 0);
    endtask

    initial begin
        logic [7:0] fb [4];
        logic       a, bz;
        int         n;

        wait_clk(5);
        @(negedge clk);
        check("rst_oe", {31'd0, i2c_sdat_oe}, 0);
        check("rst_wr_valid", {31'd0, wr_valid}, 0);
        check("rst_wr_data", {16'd0, wr_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        rst_n = 1'b1;
        wait_clk(20);

        fb = '{8'h34, 8'h1E, 8'h00, 8'h00};
        run_frame(fb, 3);
        fb = '{8'h36, 8'h0C, 8'h55, 8'h00};
        run_frame(fb, 3);
        fb = '{8'h35, 8'hAA, 8'h55, 8'h00};
        run_frame(fb, 3);
        fb = '{8'h34, 8'h08, 8'h00, 8'h00};
        run_frame(fb, 2);
        fb = '{8'h34, 8'h0E, 8'h4A, 8'h00};
        run_frame(fb, 3);
        fb = '{8'h34, 8'h10, 8'h23, 8'h00};
        run_frame(fb, 3);
        fb = '{8'h34, 8'h01, 8'h02, 8'h03};
        run_frame(fb, 4);

        // Reset while the target is acknowledging the register byte
        i2c_start();
        send_bits(8'h34);
        read_ack(a, bz);
        check("rst_mid_ack_a", {31'd0, a}, 0);
        send_bits(8'h08);
        m_scl = 1'b0;
        wait_clk(32);
        m_sda = 1'b1;
        wait_clk(32);
        m_scl = 1'b1;
        wait_clk(16);
        @(negedge clk);
        check("oe_before_rst", {31'd0, i2c_sdat_oe}, 1);
        rst_n = 1'b0;
        #1;
        check("oe_async_rst", {31'd0, i2c_sdat_oe}, 0);
        check("busy_async_rst", {31'd0, busy}, 0);
        wait_clk(8);
        rst_n = 1'b1;
        wait_clk(64);
        model_wd = 16'h0000;
        check("wr_data_after_rst", {16'd0, wr_data}, 0);
        fb = '{8'h34, 8'h12, 8'h01, 8'h00};
        run_frame(fb, 3);

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 3))
                0: fb[0] = 8'h34;
                1: fb[0] = 8'h36;
                2: fb[0] = 8'h35;
                default: fb[0] = 8'($urandom);
            endcase
            fb[1] = 8'($urandom);
            fb[2] = 8'($urandom);
            fb[3] = 8'($urandom);
            n = $urandom_range(1, 4);
            run_frame(fb, n);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
